shot_cursor_ctrl: RTL and testbench

- Sits directly downstream of the button debouncers. Consumes their single-cycle press pulses (up/down/left/right/fire) on the same slow game clock.
- Maintains the player's targeting cursor on the Battleship grid.
- Tracks which cells have already been fired on, and issues one valid/ready shot request per accepted fire press to the game-logic block.

---
 rtl/shot_cursor_ctrl.sv | 126 ++++++++++++
 tb/tb_shot_cursor_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/shot_cursor_ctrl.sv
// Battleship targeting cursor, fired-cell bitmap and valid/ready shot request.
// Define CURSOR_WRAP_EN to wrap the cursor at the grid edges instead of saturating.
module shot_cursor_ctrl #(
    parameter int GRID_W  = 8,
    parameter int GRID_H  = 8,
    parameter int COORD_W = 3,
    parameter int CNT_W   = 7
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               btn_up,
    input  logic               btn_down,
    input  logic               btn_left,
    input  logic               btn_right,
    input  logic               btn_fire,
    input  logic               new_game,
    input  logic               turn_en,
    input  logic               shot_ready,
    output logic [COORD_W-1:0] cur_x,
    output logic [COORD_W-1:0] cur_y,
    output logic               shot_valid,
    output logic [COORD_W-1:0] shot_x,
    output logic [COORD_W-1:0] shot_y,
    output logic               dup_err,
    output logic [CNT_W-1:0]   shot_count
);

    localparam int NCELL = GRID_W * GRID_H;
    localparam int IDX_W = $clog2(NCELL);
    localparam logic [COORD_W-1:0] X_MAX = COORD_W'(GRID_W - 1);
    localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(GRID_H - 1);
    localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(NCELL);

    typedef enum logic {IDLE, REQ} state_t;

    state_t             state, state_next;
    logic [NCELL-1:0]   fired;
    logic [IDX_W-1:0]   cur_idx, shot_idx;
    logic               fire_req, cell_shot, accept;
    logic [COORD_W-1:0] x_next, y_next;

    assign cur_idx   = IDX_W'(cur_y) * IDX_W'(GRID_W) + IDX_W'(cur_x);
    assign shot_idx  = IDX_W'(shot_y) * IDX_W'(GRID_W) + IDX_W'(shot_x);
    assign fire_req  = btn_fire & turn_en;
    assign cell_shot = fired[cur_idx];
    assign accept    = (state == IDLE) & fire_req & ~cell_shot;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (new_game) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (accept) state_next = REQ;
                REQ:     if (shot_ready) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        shot_valid = (state == REQ);
    end

    // Opposing presses in the same cycle cancel before any edge handling.
    always_comb begin
        x_next = cur_x;
        y_next = cur_y;
`ifdef CURSOR_WRAP_EN
        if (btn_right && !btn_left)      x_next = (cur_x == X_MAX) ? '0 : cur_x + 1'b1;
        else if (btn_left && !btn_right) x_next = (cur_x == '0) ? X_MAX : cur_x - 1'b1;
        if (btn_down && !btn_up)         y_next = (cur_y == Y_MAX) ? '0 : cur_y + 1'b1;
        else if (btn_up && !btn_down)    y_next = (cur_y == '0) ? Y_MAX : cur_y - 1'b1;
`else
        if (btn_right && !btn_left && cur_x != X_MAX)    x_next = cur_x + 1'b1;
        else if (btn_left && !btn_right && cur_x != '0)  x_next = cur_x - 1'b1;
        if (btn_down && !btn_up && cur_y != Y_MAX)       y_next = cur_y + 1'b1;
        else if (btn_up && !btn_down && cur_y != '0)     y_next = cur_y - 1'b1;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_x      <= '0;
            cur_y      <= '0;
            shot_x     <= '0;
            shot_y     <= '0;
            dup_err    <= 1'b0;
            shot_count <= '0;
            fired      <= '0;
        end else if (new_game) begin
            cur_x      <= '0;
            cur_y      <= '0;
            shot_x     <= '0;
            shot_y     <= '0;
            dup_err    <= 1'b0;
            shot_count <= '0;
            fired      <= '0;
        end else begin
            dup_err <= 1'b0;
            if (state == IDLE) begin
                // Any fire with turn_en swallows the moves of that cycle, even a rejected one.
                if (fire_req) begin
                    if (cell_shot) begin
                        dup_err <= 1'b1;
                    end else begin
                        shot_x <= cur_x;
                        shot_y <= cur_y;
                    end
                end else begin
                    cur_x <= x_next;
                    cur_y <= y_next;
                end
            end else if (shot_ready) begin
                fired[shot_idx] <= 1'b1;
                if (shot_count != CNT_MAX) shot_count <= shot_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_shot_cursor_ctrl.sv
// Randomized self-checking bench for shot_cursor_ctrl against a behavioural game model.
// Honors CURSOR_WRAP_EN the same way as the design.
module tb_shot_cursor_ctrl;

    localparam int GW = 8;
    localparam int GH = 8;

    localparam logic [7:0] R   = 8'h01;
    localparam logic [7:0] L   = 8'h02;
    localparam logic [7:0] D   = 8'h04;
    localparam logic [7:0] U   = 8'h08;
    localparam logic [7:0] F   = 8'h10;
    localparam logic [7:0] RDY = 8'h20;
    localparam logic [7:0] T   = 8'h40;
    localparam logic [7:0] NG  = 8'h80;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn_up, btn_down, btn_left, btn_right, btn_fire;
    logic       new_game, turn_en, shot_ready;
    logic [2:0] cur_x, cur_y, shot_x, shot_y;
    logic       shot_valid, dup_err;
    logic [6:0] shot_count;

    int total = 0;
    int bad   = 0;

    // Reference model of the game-facing state.
    int mx, my, msx, msy, mcount;
    bit mvalid, mdup;
    bit mmap [GW*GH];

    shot_cursor_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .btn_fire   (btn_fire),
        .new_game   (new_game),
        .turn_en    (turn_en),
        .shot_ready (shot_ready),
        .cur_x      (cur_x),
        .cur_y      (cur_y),
        .shot_valid (shot_valid),
        .shot_x     (shot_x),
        .shot_y     (shot_y),
        .dup_err    (dup_err),
        .shot_count (shot_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void modelClear();
        mx = 0; my = 0; msx = 0; msy = 0; mcount = 0;
        mvalid = 0; mdup = 0;
        for (int i = 0; i < GW*GH; i++) mmap[i] = 0;
    endfunction

    function automatic int moveAxis(input int pos, input int delta, input int size);
`ifdef CURSOR_WRAP_EN
        return (pos + delta + size) % size;
`else
        if (pos + delta < 0) return 0;
        if (pos + delta > size - 1) return size - 1;
        return pos + delta;
`endif
    endfunction

    function automatic void modelStep(input logic [7:0] b);
        if (b & NG) begin
            modelClear();
        end else if (mvalid) begin
            mdup = 0;
            if (b & RDY) begin
                mmap[msy*GW + msx] = 1;
                if (mcount < GW*GH) mcount++;
                mvalid = 0;
            end
        end else begin
            mdup = 0;
            if ((b & F) && (b & T)) begin
                if (mmap[my*GW + mx]) mdup = 1;
                else begin
                    msx = mx; msy = my; mvalid = 1;
                end
            end else begin
                mx = moveAxis(mx, int'(b[0]) - int'(b[1]), GW);
                my = moveAxis(my, int'(b[2]) - int'(b[3]), GH);
            end
        end
    endfunction

    task automatic checkAll();
        checkOutput("cur_x", cur_x, mx);
        checkOutput("cur_y", cur_y, my);
        checkOutput("shot_valid", shot_valid, mvalid);
        checkOutput("dup_err", dup_err, mdup);
        checkOutput("shot_count", shot_count, mcount);
        if (mvalid) begin
            checkOutput("shot_x", shot_x, msx);
            checkOutput("shot_y", shot_y, msy);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        @(negedge clk);
        btn_right  = b[0];
        btn_left   = b[1];
        btn_down   = b[2];
        btn_up     = b[3];
        btn_fire   = b[4];
        shot_ready = b[5];
        turn_en    = b[6];
        new_game   = b[7];
        @(posedge clk);
        modelStep(b);
        #1;
        checkAll();
    endtask

    task automatic moveTo(input int x, input int y);
        for (int i = 0; i < 2*GW && mx != x; i++) applyStimulus(mx < x ? R : L);
        for (int i = 0; i < 2*GH && my != y; i++) applyStimulus(my < y ? D : U);
    endtask

    task automatic checkCleared(input string tag);
        checkOutput({tag, "_x"}, cur_x, 0);
        checkOutput({tag, "_y"}, cur_y, 0);
        checkOutput({tag, "_valid"}, shot_valid, 0);
        checkOutput({tag, "_dup"}, dup_err, 0);
        checkOutput({tag, "_count"}, shot_count, 0);
        checkOutput({tag, "_sx"}, shot_x, 0);
        checkOutput({tag, "_sy"}, shot_y, 0);
    endtask

    initial begin
        int vcycles;
        logic [7:0] b;

        rst_n = 1'b0;
        {btn_up, btn_down, btn_left, btn_right, btn_fire} = '0;
        {new_game, turn_en, shot_ready} = '0;
        modelClear();
        #12;
        checkCleared("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Basic movement and cancelling opposing presses.
        repeat (3) applyStimulus(R);
        repeat (2) applyStimulus(D);
        checkOutput("plan_x3", cur_x, 3);
        checkOutput("plan_y2", cur_y, 2);
        applyStimulus(L | R);
        checkOutput("plan_cancel_x", cur_x, 3);

        // Right edge behaviour.
        repeat (10) applyStimulus(R);
`ifndef CURSOR_WRAP_EN
        checkOutput("plan_sat_right", cur_x, 7);
`endif
        moveTo(0, my);
        applyStimulus(L);
`ifdef CURSOR_WRAP_EN
        checkOutput("plan_wrap_left", cur_x, 7);
`else
        checkOutput("plan_sat_left", cur_x, 0);
`endif

        // Held request with moves ignored, then completion.
        moveTo(3, 2);
        applyStimulus(F | T);
        vcycles = 1;
        for (int i = 0; i < 4; i++) begin
            applyStimulus((i % 2 == 0) ? (R | D | T) : (L | U | F | T));
            if (shot_valid) vcycles++;
        end
        checkOutput("plan_valid_cycles", vcycles, 5);
        checkOutput("plan_req_x", shot_x, 3);
        checkOutput("plan_req_y", shot_y, 2);
        applyStimulus(RDY);
        checkOutput("plan_count1", shot_count, 1);
        checkOutput("plan_cursor_kept", cur_x, 3);

        // Duplicate shot and fire while not our turn.
        applyStimulus(F | T);
        checkOutput("plan_dup", dup_err, 1);
        checkOutput("plan_dup_novalid", shot_valid, 0);
        applyStimulus(0);
        checkOutput("plan_dup_pulse", dup_err, 0);
        applyStimulus(F);
        checkOutput("plan_noturn_valid", shot_valid, 0);
        checkOutput("plan_noturn_dup", dup_err, 0);

        // Fire beats a simultaneous move; one-cycle handshake.
        moveTo(0, 0);
        applyStimulus(F | T | R);
        checkOutput("plan_fire_prio_x", cur_x, 0);
        checkOutput("plan_fire_prio_valid", shot_valid, 1);
        applyStimulus(RDY);
        applyStimulus(F | T | RDY);
        checkOutput("plan_dup00", dup_err, 1);

        // new_game coincident with a completing handshake.
        moveTo(5, 5);
        applyStimulus(F | T);
        applyStimulus(NG | RDY);
        checkOutput("plan_ng_count", shot_count, 0);
        checkOutput("plan_ng_valid", shot_valid, 0);
        moveTo(3, 2);
        applyStimulus(F | T);
        checkOutput("plan_ng_refire", shot_valid, 1);

        // Asynchronous reset in the middle of a request.
        #2;
        rst_n = 1'b0;
        #1;
        checkCleared("async_reset");
        modelClear();
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            b = '0;
            if ($urandom_range(3) == 0) b |= R;
            if ($urandom_range(3) == 0) b |= L;
            if ($urandom_range(3) == 0) b |= D;
            if ($urandom_range(3) == 0) b |= U;
            if ($urandom_range(4) == 0) b |= F;
            if ($urandom_range(2) == 0) b |= RDY;
            if ($urandom_range(3) != 0) b |= T;
            if ($urandom_range(199) == 0) b |= NG;
            applyStimulus(b);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
